// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and sizing helpers for the sequence generator and detectors
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_gen_state_t;

    localparam int PAT_W_DEFAULT = 8;
    localparam int REP_W_DEFAULT = 4;

    // Width of a field able to hold any length from 0 to pat_w inclusive.
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - control and serial-output bundle of the pattern generator
interface seq_pattern_gen_if #(
    parameter int PAT_W = seq_pkg::PAT_W_DEFAULT,
    parameter int REP_W = seq_pkg::REP_W_DEFAULT
);
    import seq_pkg::*;

    localparam int LEN_W = len_width(PAT_W);

    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] rep;
    logic             stall;
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, rep, stall,
        input  x, valid, busy, done
    );

    modport slave (
        input  start, pattern, len, rep, stall,
        output x, valid, busy, done
    );

endinterface

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down counter that saturates at zero
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial test-pattern generator, MSB-first with repeats and stall
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEFAULT,
    parameter int REP_W = REP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              clr,
    seq_pattern_gen_if.slave  bus
);

    localparam int LEN_W = len_width(PAT_W);
    localparam int BIT_W = $clog2(PAT_W);

    seq_gen_state_t   state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [BIT_W-1:0] len_m1_q, len_m1_d;
    logic             x_q, x_d;
    logic             valid_q, valid_d;

    logic             bit_load, bit_en, bit_zero;
    logic [BIT_W-1:0] bit_load_val, bit_cnt, bit_nxt;
    logic             pass_load, pass_en, pass_zero;
    logic [REP_W-1:0] pass_cnt;

    logic [LEN_W-1:0] len_c;
    logic [BIT_W-1:0] len_m1_c;
    logic             accept;

    assign len_c    = (bus.len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.len;
    assign len_m1_c = BIT_W'(len_c - LEN_W'(1));
    assign accept   = bus.start && (bus.len != '0);
    assign bit_nxt  = bit_cnt - BIT_W'(1);

    seq_down_counter #(.W(BIT_W)) u_bit_cnt (
        .clk      (clk),
        .clr      (clr),
        .load     (bit_load),
        .en       (bit_en),
        .load_val (bit_load_val),
        .count    (bit_cnt),
        .zero     (bit_zero)
    );

    seq_down_counter #(.W(REP_W)) u_pass_cnt (
        .clk      (clk),
        .clr      (clr),
        .load     (pass_load),
        .en       (pass_en),
        .load_val (bus.rep),
        .count    (pass_cnt),
        .zero     (pass_zero)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            len_m1_q <= '0;
            x_q      <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            len_m1_q <= len_m1_d;
            x_q      <= x_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (!bus.stall && bit_zero && pass_zero) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters track the bit currently on x; each edge prepares the following one.
    always_comb begin
        pat_d        = pat_q;
        len_m1_d     = len_m1_q;
        x_d          = x_q;
        valid_d      = 1'b0;
        bit_load     = 1'b0;
        bit_en       = 1'b0;
        bit_load_val = len_m1_q;
        pass_load    = 1'b0;
        pass_en      = 1'b0;
        case (state_q)
            IDLE: begin
                x_d = 1'b0;
                if (accept) begin
                    pat_d        = bus.pattern;
                    len_m1_d     = len_m1_c;
                    bit_load     = 1'b1;
                    bit_load_val = len_m1_c;
                    pass_load    = 1'b1;
                    x_d          = bus.pattern[len_m1_c];
                    valid_d      = 1'b1;
                end
            end
            SHIFT: begin
                if (!bus.stall) begin
                    if (bit_zero) begin
                        if (pass_zero) begin
                            x_d = 1'b0;
                        end else begin
                            bit_load = 1'b1;
                            pass_en  = 1'b1;
                            x_d      = pat_q[len_m1_q];
                            valid_d  = 1'b1;
                        end
                    end else begin
                        bit_en  = 1'b1;
                        x_d     = pat_q[bit_nxt];
                        valid_d = 1'b1;
                    end
                end
            end
            default: x_d = 1'b0;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q != IDLE);
        bus.done  = (state_q == DONE);
        bus.x     = x_q;
        bus.valid = valid_q;
    end

endmodule
